// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fetch-state encoding,
// instruction field bit positions and the lowest opcode that gets issued.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int SH_MSB   = 10;
  localparam int SH_LSB   = 6;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int ADDR_MSB = 25;
  localparam int ADDR_LSB = 0;

  // Opcodes below this value are fetched but never handed to the executor.
  localparam logic [5:0] INST_NUM_MIN_VALID = 6'd4;

endpackage

// File: rtl/inst_fetch_unit_decoder.sv
// inst_decoder: purely combinational split of a 32-bit instruction word
// into opcode, register indices and immediates.
module inst_decoder
  import inst_fetch_unit_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [5:0]  inst_num_o,
  output logic [4:0]  rs_idx_o,
  output logic [4:0]  rt_idx_o,
  output logic [4:0]  rd_idx_o,
  output logic [4:0]  shift5_o,
  output logic [15:0] const16_o,
  output logic [25:0] addr26_o
);

  assign inst_num_o = inst_i[OPC_MSB:OPC_LSB];
  assign rs_idx_o   = inst_i[RS_MSB:RS_LSB];
  assign rt_idx_o   = inst_i[RT_MSB:RT_LSB];
  assign rd_idx_o   = inst_i[RD_MSB:RD_LSB];
  assign shift5_o   = inst_i[SH_MSB:SH_LSB];
  assign const16_o  = inst_i[IMM_MSB:IMM_LSB];
  assign addr26_o   = inst_i[ADDR_MSB:ADDR_LSB];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: request, capture, decode and issue one word at a time.
// Optional retired-instruction counter is built when INST_COUNT_EN is defined.
//   state | meaning
//   REQ   | fetch request outstanding at pc, waiting for imem_ready
//   WAIT  | request accepted, waiting for imem_data_ready
//   ISSUE | decoded word presented to executor until exec_completed
//   HALT  | stopped (halt or misaligned pc) until reset
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_valid,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        imem_data_ready,
  output logic [31:0] pc,
  output logic [5:0]  inst_num,
  output logic [15:0] const16,
  output logic [4:0]  shift5,
  output logic [25:0] addr26,
  output logic [4:0]  rs_idx,
  output logic [4:0]  rt_idx,
  output logic [4:0]  rd_idx,
  output logic        issue_valid,
  input  logic        exec_completed,
  input  logic [31:0] exec_pc_out,
  input  logic        halted,
  output logic        fault
`ifdef INST_COUNT_EN
  ,
  output logic [31:0] retired_count
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         fault_q, fault_d;
  logic         imem_valid_q, issue_valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    case (state_q)
      ST_REQ: begin
        // Only a misaligned RESET_PC can reach here unaligned.
        if (pc_q[1:0] != 2'b00) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else if (imem_valid_q && imem_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_data_ready) begin
          ir_d = imem_data;
          if (imem_data[OPC_MSB:OPC_LSB] < INST_NUM_MIN_VALID) begin
            pc_d    = pc_q + 32'd4;
            state_d = ST_REQ;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (exec_completed) begin
          pc_d = exec_pc_out;
          if (exec_pc_out[1:0] != 2'b00) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else if (halted) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Handshake outputs are registered from the next state so they are 0 in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      ir_q          <= 32'd0;
      fault_q       <= 1'b0;
      imem_valid_q  <= 1'b0;
      issue_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      fault_q       <= fault_d;
      imem_valid_q  <= (state_d == ST_REQ);
      issue_valid_q <= (state_d == ST_ISSUE);
    end
  end

`ifdef INST_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 32'd0;
    end else if (state_q == ST_ISSUE && exec_completed) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_count = retired_q;
`endif

  assign imem_addr   = pc_q;
  assign imem_valid  = imem_valid_q;
  assign pc          = pc_q;
  assign issue_valid = issue_valid_q;
  assign fault       = fault_q;

  inst_decoder u_decoder (
    .inst_i     (ir_q),
    .inst_num_o (inst_num),
    .rs_idx_o   (rs_idx),
    .rt_idx_o   (rt_idx),
    .rd_idx_o   (rd_idx),
    .shift5_o   (shift5),
    .const16_o  (const16),
    .addr26_o   (addr26)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'h0000_0102;

  localparam logic [1:0] P_REQ  = 2'd0;
  localparam logic [1:0] P_WAIT = 2'd1;
  localparam logic [1:0] P_ISS  = 2'd2;
  localparam logic [1:0] P_STOP = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic        imem_data_ready = 1'b0;
  logic        exec_completed = 1'b0;
  logic [31:0] exec_pc_out = 32'd0;
  logic        halted = 1'b0;

  logic [31:0] imem_addr, pc;
  logic        imem_valid, issue_valid, fault;
  logic [5:0]  inst_num;
  logic [15:0] const16;
  logic [4:0]  shift5, rs_idx, rt_idx, rd_idx;
  logic [25:0] addr26;

  logic [31:0] imem_addr2, pc2;
  logic        imem_valid2, issue_valid2, fault2;
  logic [5:0]  inst_num2;
  logic [15:0] const16_2;
  logic [4:0]  shift5_2, rs_idx2, rt_idx2, rd_idx2;
  logic [25:0] addr26_2;

`ifdef INST_COUNT_EN
  logic [31:0] retired_count, retired_count2;
`endif

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_ready(imem_ready),
    .imem_data(imem_data), .imem_data_ready(imem_data_ready),
    .pc(pc), .inst_num(inst_num), .const16(const16), .shift5(shift5), .addr26(addr26),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx), .issue_valid(issue_valid),
    .exec_completed(exec_completed), .exec_pc_out(exec_pc_out), .halted(halted),
    .fault(fault)
`ifdef INST_COUNT_EN
    , .retired_count(retired_count)
`endif
  );

  inst_fetch_unit #(.RESET_PC(RPC2)) dut_mis (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr2), .imem_valid(imem_valid2), .imem_ready(imem_ready),
    .imem_data(imem_data), .imem_data_ready(imem_data_ready),
    .pc(pc2), .inst_num(inst_num2), .const16(const16_2), .shift5(shift5_2), .addr26(addr26_2),
    .rs_idx(rs_idx2), .rt_idx(rt_idx2), .rd_idx(rd_idx2), .issue_valid(issue_valid2),
    .exec_completed(exec_completed), .exec_pc_out(exec_pc_out), .halted(halted),
    .fault(fault2)
`ifdef INST_COUNT_EN
    , .retired_count(retired_count2)
`endif
  );

  // Transaction-level reference: where the fetch is, what pc and word are.
  typedef struct packed {
    logic [1:0]  phase;
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
    logic        fresh;
    logic [31:0] retired;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mreset();
    mdl_t n;
    n.phase   = P_REQ;
    n.pc      = RPC;
    n.word    = 32'd0;
    n.fault   = 1'b0;
    n.fresh   = 1'b1;
    n.retired = 32'd0;
    return n;
  endfunction

  function automatic mdl_t mstep(input mdl_t cur, input logic rdy, input logic drdy,
                                 input logic [31:0] data, input logic ec,
                                 input logic [31:0] epc, input logic hlt);
    mdl_t n = cur;
    logic [31:0] opc;
    opc = data >> 26;
    if (cur.fresh) begin
      n.fresh = 1'b0;
      if (RPC % 4 != 0) begin
        n.phase = P_STOP;
        n.fault = 1'b1;
      end
      return n;
    end
    case (cur.phase)
      P_REQ:  if (rdy) n.phase = P_WAIT;
      P_WAIT: if (drdy) begin
        n.word = data;
        if (opc < 4) begin
          n.pc    = cur.pc + 32'd4;
          n.phase = P_REQ;
        end else begin
          n.phase = P_ISS;
        end
      end
      P_ISS: if (ec) begin
        n.pc      = epc;
        n.retired = cur.retired + 32'd1;
        if (epc % 4 != 0) begin
          n.fault = 1'b1;
          n.phase = P_STOP;
        end else if (hlt) begin
          n.phase = P_STOP;
        end else begin
          n.phase = P_REQ;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= mreset();
    else       m <= mstep(m, imem_ready, imem_data_ready, imem_data,
                          exec_completed, exec_pc_out, halted);
  end

  always @(posedge clk) begin
    if (!reset && imem_valid && imem_ready) xfers <= xfers + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic exp_v;
    exp_v = (m.phase == P_REQ) && !m.fresh;
    if (check_en) begin
      chk("imem_valid", {31'd0, imem_valid}, {31'd0, exp_v});
      if (exp_v) chk("imem_addr", imem_addr, m.pc);
      chk("issue_valid", {31'd0, issue_valid}, {31'd0, m.phase == P_ISS});
      chk("pc", pc, m.pc);
      chk("fault", {31'd0, fault}, {31'd0, m.fault});
      chk("inst_num", {26'd0, inst_num}, {26'd0, m.word[31:26]});
      chk("rs_idx", {27'd0, rs_idx}, {27'd0, m.word[25:21]});
      chk("rt_idx", {27'd0, rt_idx}, {27'd0, m.word[20:16]});
      chk("rd_idx", {27'd0, rd_idx}, {27'd0, m.word[15:11]});
      chk("shift5", {27'd0, shift5}, {27'd0, m.word[10:6]});
      chk("const16", {16'd0, const16}, {16'd0, m.word[15:0]});
      chk("addr26", {6'd0, addr26}, {6'd0, m.word[25:0]});
`ifdef INST_COUNT_EN
      chk("retired_count", retired_count, m.retired);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ready = 1'b0; imem_data_ready = 1'b0; exec_completed = 1'b0;
    halted = 1'b0; exec_pc_out = 32'd0; imem_data = 32'd0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!imem_valid && n < 100) begin
      tick();
      n++;
    end
    chk("wait_imem_valid", {31'd0, imem_valid}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] word, input int lat);
    wait_valid();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    repeat (lat - 1) tick();
    imem_data = word;
    imem_data_ready = 1'b1;
    tick();
    imem_data_ready = 1'b0;
    imem_data = $urandom;
  endtask

  task automatic complete(input logic [31:0] target, input logic hlt);
    exec_completed = 1'b1;
    exec_pc_out = target;
    halted = hlt;
    tick();
    exec_completed = 1'b0;
    halted = 1'b0;
  endtask

  initial begin
    int xfer0, pulses;
    logic [31:0] r;
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    check_en = 1'b1;

    // Reset values, and a misaligned RESET_PC faulting on the first edge.
    chk("rst_valid", {31'd0, imem_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("mis_rst_fault", {31'd0, fault2}, 32'd0);
    reset = 1'b0;
    tick();
    chk("mis_fault", {31'd0, fault2}, 32'd1);
    chk("mis_valid", {31'd0, imem_valid2}, 32'd0);
    chk("mis_pc", pc2, 32'h102);

    // Stalled request then normal flow.
    xfer0 = xfers;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, imem_valid}, 32'd1);
      chk("stall_addr", imem_addr, 32'h0);
      tick();
    end
    fetch(32'h2043_0005, 2);
    chk("one_transfer", xfers - xfer0, 32'd1);
    chk("norm_issue", {31'd0, issue_valid}, 32'd1);
    chk("norm_inst_num", {26'd0, inst_num}, 32'd8);
    chk("norm_rs", {27'd0, rs_idx}, 32'd2);
    chk("norm_rt", {27'd0, rt_idx}, 32'd3);
    chk("norm_const16", {16'd0, const16}, 32'd5);
    repeat (3) tick();
    chk("issue_hold", {31'd0, issue_valid}, 32'd1);
    complete(32'h4, 1'b0);
    chk("norm_issue_fall", {31'd0, issue_valid}, 32'd0);
    chk("norm_next_addr", imem_addr, 32'h4);

    // Skipped words.
    fetch(32'h0C00_0001, 1);
    chk("skip3_addr", imem_addr, 32'h8);
    fetch(32'h0000_0000, 3);
    chk("skip0_issue", {31'd0, issue_valid}, 32'd0);
    chk("skip0_addr", imem_addr, 32'hC);

    // Halt with target 0x40.
    fetch(32'h1000_0000, 1);
    chk("halt_pre_issue", {31'd0, issue_valid}, 32'd1);
    complete(32'h40, 1'b1);
    chk("halt_pc", pc, 32'h40);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      imem_ready = $urandom_range(0, 1);
      imem_data_ready = $urandom_range(0, 1);
      exec_completed = $urandom_range(0, 1);
      if (imem_valid || issue_valid) pulses++;
      tick();
    end
    idle_inputs();
    chk("halt_no_activity", pulses, 32'd0);

    // Reset during WAIT, late data_ready after release.
    reset_dut();
    wait_valid();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    imem_data = 32'h2043_0005;
    imem_data_ready = 1'b1;
    tick();
    imem_data_ready = 1'b0;
    chk("late_drdy_issue", {31'd0, issue_valid}, 32'd0);
    chk("late_drdy_valid", {31'd0, imem_valid}, 32'd1);
    chk("late_drdy_addr", imem_addr, RPC);

    // Misaligned executor target.
    fetch(32'h2000_0000, 1);
    complete(32'h6, 1'b0);
    chk("mis_tgt_fault", {31'd0, fault}, 32'd1);
    chk("mis_tgt_pc", pc, 32'h6);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      imem_ready = $urandom_range(0, 1);
      if (imem_valid) pulses++;
      tick();
    end
    chk("mis_tgt_no_fetch", pulses, 32'd0);

    // Randomized traffic, model-checked every cycle.
    for (int ep = 0; ep < 6; ep++) begin
      reset_dut();
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (m.phase == P_STOP || $urandom_range(0, 399) == 0) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
        end
        imem_ready = $urandom_range(0, 1);
        imem_data_ready = ($urandom_range(0, 2) == 0);
        r = $urandom;
        if ($urandom_range(0, 3) == 0) r = r & 32'h0FFF_FFFF;
        imem_data = r;
        exec_completed = ($urandom_range(0, 2) == 0);
        halted = ($urandom_range(0, 39) == 0);
        r = $urandom;
        exec_pc_out = (r & 32'hFFFF_FFFC);
        if ($urandom_range(0, 49) == 0) exec_pc_out = r | 32'h1;
        tick();
      end
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
